// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - DVI raster timing generator with shadow/active mode registers
// Optional frame_count port is built when VIDEO_TIMING_CTRL_FRAME_CNT_EN is defined.
module video_timing_ctrl #(
  parameter int   H_WIDTH       = 12,
  parameter int   V_WIDTH       = 12,
  parameter logic HSYNC_POL     = 1'b0,
  parameter logic VSYNC_POL     = 1'b0,
  parameter int   INIT_HTOTAL   = 800,
  parameter int   INIT_HDISP    = 640,
  parameter int   INIT_HS_START = 656,
  parameter int   INIT_HS_END   = 752,
  parameter int   INIT_VTOTAL   = 525,
  parameter int   INIT_VDISP    = 480,
  parameter int   INIT_VS_START = 490,
  parameter int   INIT_VS_END   = 492
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        cfg_update,
  output logic        cfg_update_ack,
  input  logic        ctl_enable,
  output logic        ctl_busy,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_de,
  output logic        out_frame_start
`ifdef VIDEO_TIMING_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Bank layout shared by the h and v register sets.
  localparam int TOT = 0;
  localparam int DSP = 1;
  localparam int SST = 2;
  localparam int SEN = 3;

  localparam logic [H_WIDTH:0] H_ONE = {{H_WIDTH{1'b0}}, 1'b1};
  localparam logic [V_WIDTH:0] V_ONE = {{V_WIDTH{1'b0}}, 1'b1};

  function automatic logic [H_WIDTH-1:0] h_init(input int idx);
    case (idx)
      TOT:     return H_WIDTH'(INIT_HTOTAL);
      DSP:     return H_WIDTH'(INIT_HDISP);
      SST:     return H_WIDTH'(INIT_HS_START);
      default: return H_WIDTH'(INIT_HS_END);
    endcase
  endfunction

  function automatic logic [V_WIDTH-1:0] v_init(input int idx);
    case (idx)
      TOT:     return V_WIDTH'(INIT_VTOTAL);
      DSP:     return V_WIDTH'(INIT_VDISP);
      SST:     return V_WIDTH'(INIT_VS_START);
      default: return V_WIDTH'(INIT_VS_END);
    endcase
  endfunction

  state_t state, state_nxt;

  logic [H_WIDTH-1:0] sh_h  [4];
  logic [V_WIDTH-1:0] sh_v  [4];
  logic [H_WIDTH-1:0] act_h [4];
  logic [V_WIDTH-1:0] act_v [4];

  logic [H_WIDTH-1:0] hcnt, hcnt_nxt;
  logic [V_WIDTH-1:0] vcnt, vcnt_nxt;
  logic [H_WIDTH:0]   hcnt_p1;
  logic [V_WIDTH:0]   vcnt_p1;
  logic               h_last, v_last, boundary;
  logic               pending, pending_nxt;
  logic               copy_req, copy, ack_nxt;
  logic               running;
  logic               de_nxt, hs_nxt, vs_nxt, fs_nxt;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  // A total of 0 or 1 makes the "last" test true at 0, so the counter parks there.
  assign hcnt_p1  = {1'b0, hcnt} + H_ONE;
  assign vcnt_p1  = {1'b0, vcnt} + V_ONE;
  assign h_last   = hcnt_p1 >= {1'b0, act_h[TOT]};
  assign v_last   = vcnt_p1 >= {1'b0, act_v[TOT]};
  assign boundary = h_last && v_last;
  assign copy_req = pending || cfg_update;
  assign running  = (state != IDLE);
  assign ctl_busy = running;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hcnt_nxt    = hcnt;
    vcnt_nxt    = vcnt;
    copy        = 1'b0;
    ack_nxt     = 1'b0;
    pending_nxt = copy_req;
    case (state)
      IDLE: begin
        hcnt_nxt = '0;
        vcnt_nxt = '0;
        if (ctl_enable) begin
          state_nxt = RUN;
          copy      = 1'b1;
        end else if (pending) begin
          copy = 1'b1;
        end
        ack_nxt = copy && copy_req;
      end
      RUN, STOP: begin
        if (h_last) begin
          hcnt_nxt = '0;
          vcnt_nxt = v_last ? '0 : vcnt_p1[V_WIDTH-1:0];
        end else begin
          hcnt_nxt = hcnt_p1[H_WIDTH-1:0];
        end
        copy    = boundary && copy_req;
        ack_nxt = copy;
        if (state == RUN) begin
          if (!ctl_enable) state_nxt = STOP;
        end else if (ctl_enable) begin
          state_nxt = RUN;
        end else if (boundary) begin
          state_nxt = IDLE;
          hcnt_nxt  = '0;
          vcnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (ack_nxt) pending_nxt = 1'b0;
  end

  // Decode uses the current counters; the registered result lags them by one clock.
  always_comb begin
    de_nxt = running && (hcnt < act_h[DSP]) && (vcnt < act_v[DSP]);
    hs_nxt = running && (hcnt >= act_h[SST]) && (hcnt < act_h[SEN]);
    vs_nxt = running && (vcnt >= act_v[SST]) && (vcnt < act_v[SEN]);
    fs_nxt = running && (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt            <= '0;
      vcnt            <= '0;
      pending         <= 1'b0;
      cfg_update_ack  <= 1'b0;
      out_de          <= 1'b0;
      out_hsync       <= ~HSYNC_POL;
      out_vsync       <= ~VSYNC_POL;
      out_frame_start <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_h[i]  <= h_init(i);
        sh_v[i]  <= v_init(i);
        act_h[i] <= h_init(i);
        act_v[i] <= v_init(i);
      end
    end else begin
      hcnt            <= hcnt_nxt;
      vcnt            <= vcnt_nxt;
      pending         <= pending_nxt;
      cfg_update_ack  <= ack_nxt;
      out_de          <= de_nxt;
      out_hsync       <= hs_nxt ? HSYNC_POL : ~HSYNC_POL;
      out_vsync       <= vs_nxt ? VSYNC_POL : ~VSYNC_POL;
      out_frame_start <= fs_nxt;
      // Copy reads shadow before this edge's write lands, so a same-cycle write only hits shadow.
      if (copy) begin
        for (int i = 0; i < 4; i++) begin
          act_h[i] <= sh_h[i];
          act_v[i] <= sh_v[i];
        end
      end
      if (cfg_we) begin
        if (!cfg_addr[2]) sh_h[cfg_addr[1:0]] <= cfg_wdata[H_WIDTH-1:0];
        else              sh_v[cfg_addr[1:0]] <= cfg_wdata[V_WIDTH-1:0];
      end
    end
  end

`ifdef VIDEO_TIMING_CTRL_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if ((state == IDLE) && ctl_enable) begin
      frame_count <= '0;
    end else if (fs_nxt) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - directed self-checking bench for video_timing_ctrl
module tb_video_timing_ctrl;

  logic        clk, reset, cfg_we, cfg_update, ctl_enable;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_update_ack, ctl_busy, out_hsync, out_vsync, out_de, out_frame_start;
`ifdef VIDEO_TIMING_CTRL_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  int total = 0;
  int bad   = 0;
  bit b_de [1024];
  bit b_hs [1024];
  bit b_vs [1024];
  bit b_fs [1024];
  bit b_ack [1024];
  bit b_busy [1024];
  int n_de, n_hs, n_vs, n_fs, n_ack, n_busy;
  int rise [$];

  video_timing_ctrl #(
    .HSYNC_POL(1'b1),
    .VSYNC_POL(1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_update     (cfg_update),
    .cfg_update_ack (cfg_update_ack),
    .ctl_enable     (ctl_enable),
    .ctl_busy       (ctl_busy),
    .out_hsync      (out_hsync),
    .out_vsync      (out_vsync),
    .out_de         (out_de),
    .out_frame_start(out_frame_start)
`ifdef VIDEO_TIMING_CTRL_FRAME_CNT_EN
    ,
    .frame_count    (frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Samples the current negedge first, then advances; index i is i cycles from now.
  task automatic run_count(input int n);
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_ack = 0; n_busy = 0;
    for (int i = 0; i < n; i++) begin
      b_de[i] = out_de;  b_hs[i] = out_hsync; b_vs[i] = out_vsync;
      b_fs[i] = out_frame_start; b_ack[i] = cfg_update_ack; b_busy[i] = ctl_busy;
      if (out_de) n_de++;
      if (out_hsync) n_hs++;
      if (out_vsync) n_vs++;
      if (out_frame_start) n_fs++;
      if (cfg_update_ack) n_ack++;
      if (ctl_busy) n_busy++;
      @(negedge clk);
    end
  endtask

  task automatic wait_fs(input string tag, input int lim);
    int k = 0;
    while (out_frame_start !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check1(tag, out_frame_start, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k = 0;
    while (ctl_busy !== 1'b0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check1(tag, ctl_busy, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic small_mode();
    wr(3'd0, 16'd10); wr(3'd1, 16'd6); wr(3'd2, 16'd7); wr(3'd3, 16'd9);
    wr(3'd4, 16'd5);  wr(3'd5, 16'd3); wr(3'd6, 16'd4); wr(3'd7, 16'd5);
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_update = 1'b0; ctl_enable = 1'b0;
    step(2);

    // reset state
    check1("rst_ack", cfg_update_ack, 1'b0);
    check1("rst_busy", ctl_busy, 1'b0);
    check1("rst_de", out_de, 1'b0);
    check1("rst_fs", out_frame_start, 1'b0);
    check1("rst_hs", out_hsync, 1'b0);
    check1("rst_vs", out_vsync, 1'b0);
`ifdef VIDEO_TIMING_CTRL_FRAME_CNT_EN
    checkn("rst_fc", int'(frame_count), 0);
`endif
    reset = 1'b0;
    step(1);

    // 1: default 640x480 mode, two lines from frame start
    ctl_enable = 1'b1;
    wait_fs("t1_fs", 5);
    check1("t1_busy", ctl_busy, 1'b1);
    run_count(800);
    checkn("t1_de_line0", n_de, 640);
    checkn("t1_hs_line0", n_hs, 96);
    checkn("t1_fs_line0", n_fs, 1);
    check1("t1_hs655", b_hs[655], 1'b0);
    check1("t1_hs656", b_hs[656], 1'b1);
    check1("t1_hs752", b_hs[752], 1'b0);
    run_count(800);
    checkn("t1_de_line1", n_de, 640);
    checkn("t1_fs_line1", n_fs, 0);
    check1("t1_hs656_line1", b_hs[656], 1'b1);
    ctl_enable = 1'b0;
    pulse_reset();

    // 2: small mode; IDLE update copies the next cycle with ack
    small_mode();
    cfg_update = 1'b1;
    step(1);
    cfg_update = 1'b0;
    check1("t2_idle_ack_early", cfg_update_ack, 1'b0);
    step(1);
    check1("t2_idle_ack", cfg_update_ack, 1'b1);
    step(1);
    check1("t2_idle_ack_end", cfg_update_ack, 1'b0);
    check1("t2_idle_de", out_de, 1'b0);
    ctl_enable = 1'b1;
    wait_fs("t2_fs", 5);
    run_count(50);
    checkn("t2_de", n_de, 18);
    checkn("t2_hs", n_hs, 10);
    checkn("t2_vs", n_vs, 10);
    checkn("t2_fs", n_fs, 1);
    check1("t2_de5", b_de[5], 1'b1);
    check1("t2_de6", b_de[6], 1'b0);
    check1("t2_hs6", b_hs[6], 1'b0);
    check1("t2_hs7", b_hs[7], 1'b1);
    check1("t2_hs8", b_hs[8], 1'b1);
    check1("t2_hs9", b_hs[9], 1'b0);
    check1("t2_vs39", b_vs[39], 1'b0);
    check1("t2_vs40", b_vs[40], 1'b1);
    check1("t2_fs50", out_frame_start, 1'b1);

    // 3: retune htotal mid-frame; copy lands at the boundary only
    step(20);
    wr(3'd0, 16'd12);
    cfg_update = 1'b1;
    step(1);
    cfg_update = 1'b0;
    run_count(88);
    checkn("t3_ack_cnt", n_ack, 1);
    check1("t3_ack_at_boundary", b_ack[27], 1'b1);
    check1("t3_fs_new", b_fs[28], 1'b1);
    rise.delete();
    for (int i = 1; i < 88; i++) if (b_hs[i] && !b_hs[i-1]) rise.push_back(i);
    checkn("t3_nrise", rise.size(), 8);
    checkn("t3_old_line", rise[1] - rise[0], 10);
    checkn("t3_cross_line", rise[3] - rise[2], 10);
    checkn("t3_new_line", rise[4] - rise[3], 12);
    checkn("t3_new_line2", rise[5] - rise[4], 12);
    check1("t3_fs60", out_frame_start, 1'b1);

    // 4a: drop enable on line 1; runs to the boundary then idles
    step(12);
    ctl_enable = 1'b0;
    run_count(60);
    check1("t4_busy_pre", b_busy[46], 1'b1);
    check1("t4_busy_post", b_busy[47], 1'b0);
    checkn("t4_de", n_de, 12);
    checkn("t4_hs", n_hs, 8);
    checkn("t4_vs", n_vs, 12);
    checkn("t4_fs", n_fs, 0);
    check1("t4_vs_idle", b_vs[48], 1'b0);

    // 4b: drop on line 1, re-raise on line 2; cadence unbroken
    ctl_enable = 1'b1;
    wait_fs("t4b_fs", 5);
    step(12);
    ctl_enable = 1'b0;
    step(12);
    ctl_enable = 1'b1;
    run_count(37);
    checkn("t4b_busy", n_busy, 37);
    check1("t4b_fs60", b_fs[36], 1'b1);
    run_count(59);
    checkn("t4b_fs_between", n_fs, 0);
    check1("t4b_fs120", out_frame_start, 1'b1);

    // 5: reset at hcnt=5, vcnt=2 with an update pending
    step(20);
    wr(3'd0, 16'd10);
    cfg_update = 1'b1;
    step(1);
    cfg_update = 1'b0;
    step(6);
    reset = 1'b1;
    #1;
    check1("t5_busy", ctl_busy, 1'b0);
    check1("t5_de", out_de, 1'b0);
    check1("t5_hs", out_hsync, 1'b0);
    check1("t5_vs", out_vsync, 1'b0);
    check1("t5_ack", cfg_update_ack, 1'b0);
    ctl_enable = 1'b0;
    step(2);
    reset = 1'b0;
    run_count(20);
    checkn("t5_no_ack", n_ack, 0);
    ctl_enable = 1'b1;
    wait_fs("t5_fs", 5);
    run_count(800);
    checkn("t5_init_de", n_de, 640);
    checkn("t5_init_hs", n_hs, 96);
    checkn("t5_init_ack", n_ack, 0);
    ctl_enable = 1'b0;

`ifdef VIDEO_TIMING_CTRL_FRAME_CNT_EN
    // 6: frame counter
    pulse_reset();
    checkn("t6_rst_fc", int'(frame_count), 0);
    small_mode();
    ctl_enable = 1'b1;
    wait_fs("t6_fs", 5);
    checkn("t6_fc1", int'(frame_count), 1);
    step(100);
    checkn("t6_fc3", int'(frame_count), 3);
    ctl_enable = 1'b0;
    wait_idle("t6_idle", 60);
    checkn("t6_fc_hold", int'(frame_count), 3);
    ctl_enable = 1'b1;
    step(1);
    checkn("t6_fc_clr", int'(frame_count), 0);
    wait_fs("t6_fs2", 5);
    checkn("t6_fc_again", int'(frame_count), 1);
    ctl_enable = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
